// File: rtl/collision_ctrl.sv
// Game-state and collision controller: snapshots the four rectangles on each frame strobe,
// evaluates overlap/pass over a 3-cycle pipeline and runs the IDLE/PLAY/HIT/OVER FSM.
module collision_ctrl #(
  parameter int unsigned HIT_FRAMES  = 2,
  parameter int unsigned OVER_FRAMES = 60,
  parameter int unsigned SCORE_MAX   = 99
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_frame,
  input  logic        i_flap,
  input  logic [11:0] i_bird_x1,
  input  logic [11:0] i_bird_x2,
  input  logic [11:0] i_bird_y1,
  input  logic [11:0] i_bird_y2,
  input  logic [11:0] i_top_x1,
  input  logic [11:0] i_top_x2,
  input  logic [11:0] i_top_y1,
  input  logic [11:0] i_top_y2,
  input  logic [11:0] i_bot_x1,
  input  logic [11:0] i_bot_x2,
  input  logic [11:0] i_bot_y1,
  input  logic [11:0] i_bot_y2,
  input  logic [11:0] i_gnd_x1,
  input  logic [11:0] i_gnd_x2,
  input  logic [11:0] i_gnd_y1,
  input  logic [11:0] i_gnd_y2,
  output logic [1:0]  o_state,
  output logic        o_playing,
  output logic        o_hit,
  output logic [7:0]  o_score,
  output logic        o_rst_world
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StHit  = 2'd2,
    StOver = 2'd3
  } state_e;

  typedef struct packed {
    logic [11:0] x1;
    logic [11:0] x2;
    logic [11:0] y1;
    logic [11:0] y2;
  } rect_t;

  localparam logic [3:0] HitFramesC  = 4'(HIT_FRAMES);
  localparam logic [7:0] OverFramesC = 8'(OVER_FRAMES);
  localparam logic [7:0] ScoreMaxC   = 8'(SCORE_MAX);

  // Inverted rectangles are empty; the strict compares alone would not reject them.
  function automatic logic overlap(input rect_t a, input rect_t b);
    return (a.x1 <= a.x2) && (a.y1 <= a.y2) && (b.x1 <= b.x2) && (b.y1 <= b.y2) &&
           (a.x1 < b.x2) && (b.x1 < a.x2) && (a.y1 < b.y2) && (b.y1 < a.y2);
  endfunction

  state_e      state_q, state_d;
  rect_t       bird_q, bird_d, top_q, top_d, bot_q, bot_d, gnd_q, gnd_d;
  logic        s1_valid_q, s1_valid_d;
  logic        s2_valid_q, s2_valid_d;
  logic        hit_flag_q, hit_flag_d;
  logic        pass_flag_q, pass_flag_d;
  logic [11:0] top_x2_q, top_x2_d;
  logic [3:0]  hit_cnt_q, hit_cnt_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]  score_q, score_d;
  logic        prev_valid_q, prev_valid_d;
  logic [11:0] prev_top_x2_q, prev_top_x2_d;
  logic        hit_q, hit_d;
  logic        rst_world_q, rst_world_d;

  always_comb begin
    bird_d        = bird_q;
    top_d         = top_q;
    bot_d         = bot_q;
    gnd_d         = gnd_q;
    s1_valid_d    = 1'b0;
    state_d       = state_q;
    hit_cnt_d     = hit_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    score_d       = score_q;
    prev_valid_d  = prev_valid_q;
    prev_top_x2_d = prev_top_x2_q;
    hit_d         = 1'b0;
    rst_world_d   = 1'b0;

    // Stage 0: snapshot, only when no evaluation is in flight.
    if (i_frame && !s1_valid_q && !s2_valid_q) begin
      s1_valid_d = 1'b1;
      bird_d     = '{x1: i_bird_x1, x2: i_bird_x2, y1: i_bird_y1, y2: i_bird_y2};
      top_d      = '{x1: i_top_x1, x2: i_top_x2, y1: i_top_y1, y2: i_top_y2};
      bot_d      = '{x1: i_bot_x1, x2: i_bot_x2, y1: i_bot_y1, y2: i_bot_y2};
      gnd_d      = '{x1: i_gnd_x1, x2: i_gnd_x2, y1: i_gnd_y1, y2: i_gnd_y2};
    end

    // Stage 1: overlap and pass flags.
    s2_valid_d  = s1_valid_q;
    hit_flag_d  = overlap(bird_q, top_q) | overlap(bird_q, bot_q) | overlap(bird_q, gnd_q);
    pass_flag_d = prev_valid_q && (prev_top_x2_q >= bird_q.x1) && (top_q.x2 < bird_q.x1);
    top_x2_d    = top_q.x2;

    // Stage 2: commit.
    unique case (state_q)
      StIdle, StOver: begin
        if (i_flap) begin
          state_d      = StPlay;
          score_d      = '0;
          hit_cnt_d    = '0;
          prev_valid_d = 1'b0;
          rst_world_d  = 1'b1;
          // Coordinates in flight predate the world restart.
          s1_valid_d   = 1'b0;
          s2_valid_d   = 1'b0;
        end
      end
      StPlay: begin
        if (s2_valid_q) begin
          prev_top_x2_d = top_x2_q;
          prev_valid_d  = 1'b1;
          if (hit_flag_q) begin
            hit_cnt_d = hit_cnt_q + 4'd1;
            if (hit_cnt_q + 4'd1 == HitFramesC) begin
              state_d     = StHit;
              hit_d       = 1'b1;
              frame_cnt_d = '0;
            end
          end else begin
            hit_cnt_d = '0;
            if (pass_flag_q && (score_q < ScoreMaxC)) score_d = score_q + 8'd1;
          end
        end
      end
      StHit: begin
        if (i_frame) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          if (frame_cnt_q + 8'd1 == OverFramesC) state_d = StOver;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= StIdle;
      s1_valid_q    <= 1'b0;
      s2_valid_q    <= 1'b0;
      hit_cnt_q     <= '0;
      frame_cnt_q   <= '0;
      score_q       <= '0;
      prev_valid_q  <= 1'b0;
      prev_top_x2_q <= '0;
      hit_q         <= 1'b0;
      rst_world_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      s1_valid_q    <= s1_valid_d;
      s2_valid_q    <= s2_valid_d;
      hit_cnt_q     <= hit_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      score_q       <= score_d;
      prev_valid_q  <= prev_valid_d;
      prev_top_x2_q <= prev_top_x2_d;
      hit_q         <= hit_d;
      rst_world_q   <= rst_world_d;
    end
  end

  // Datapath registers are qualified by the valid bits and need no reset.
  always_ff @(posedge i_clk) begin
    bird_q      <= bird_d;
    top_q       <= top_d;
    bot_q       <= bot_d;
    gnd_q       <= gnd_d;
    hit_flag_q  <= hit_flag_d;
    pass_flag_q <= pass_flag_d;
    top_x2_q    <= top_x2_d;
  end

  assign o_state     = state_q;
  assign o_playing   = (state_q == StPlay);
  assign o_hit       = hit_q;
  assign o_score     = score_q;
  assign o_rst_world = rst_world_q;

endmodule

// File: tb/tb_collision_ctrl.sv
// Directed bench for collision_ctrl: start, touching edges, hit filtering, scoring,
// saturation, HIT/OVER sequencing and mid-pipeline reset.
module tb_collision_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst, i_frame, i_flap;
  logic [11:0] bird_x1, bird_x2, bird_y1, bird_y2;
  logic [11:0] top_x1, top_x2, top_y1, top_y2;
  logic [11:0] bot_x1, bot_x2, bot_y1, bot_y2;
  logic [11:0] gnd_x1, gnd_x2, gnd_y1, gnd_y2;
  logic [1:0]  o_state;
  logic        o_playing, o_hit, o_rst_world;
  logic [7:0]  o_score;

  int vectors = 0;
  int miscompares = 0;

  always #5 i_clk = ~i_clk;

  collision_ctrl #(
    .HIT_FRAMES (2),
    .OVER_FRAMES(3),
    .SCORE_MAX  (99)
  ) u_dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_frame    (i_frame),
    .i_flap     (i_flap),
    .i_bird_x1  (bird_x1),
    .i_bird_x2  (bird_x2),
    .i_bird_y1  (bird_y1),
    .i_bird_y2  (bird_y2),
    .i_top_x1   (top_x1),
    .i_top_x2   (top_x2),
    .i_top_y1   (top_y1),
    .i_top_y2   (top_y2),
    .i_bot_x1   (bot_x1),
    .i_bot_x2   (bot_x2),
    .i_bot_y1   (bot_y1),
    .i_bot_y2   (bot_y2),
    .i_gnd_x1   (gnd_x1),
    .i_gnd_x2   (gnd_x2),
    .i_gnd_y1   (gnd_y1),
    .i_gnd_y2   (gnd_y2),
    .o_state    (o_state),
    .o_playing  (o_playing),
    .o_hit      (o_hit),
    .o_score    (o_score),
    .o_rst_world(o_rst_world)
  );

  task automatic set_top(input logic [11:0] x1, input logic [11:0] x2,
                         input logic [11:0] y1, input logic [11:0] y2);
    top_x1 = x1;
    top_x2 = x2;
    top_y1 = y1;
    top_y2 = y2;
  endtask

  // One evaluation: strobe in cycle N, early = o_hit seen in N+1/N+2, n3 = o_hit in N+3.
  task automatic run_frame(output logic n3, output logic early);
    @(negedge i_clk) i_frame = 1'b1;
    @(negedge i_clk) i_frame = 1'b0;
    early = o_hit;
    @(negedge i_clk) early = early | o_hit;
    @(negedge i_clk) n3 = o_hit;
  endtask

  task automatic do_flap();
    @(negedge i_clk) i_flap = 1'b1;
    @(negedge i_clk) i_flap = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    vectors += 5;
    if (o_state !== 2'd0) begin
      miscompares++; $display("FAIL reset_state: got %0d expected 0", o_state);
    end
    if (o_playing !== 1'b0) begin
      miscompares++; $display("FAIL reset_playing: got %b expected 0", o_playing);
    end
    if (o_hit !== 1'b0) begin
      miscompares++; $display("FAIL reset_hit: got %b expected 0", o_hit);
    end
    if (o_score !== 8'd0) begin
      miscompares++; $display("FAIL reset_score: got %0d expected 0", o_score);
    end
    if (o_rst_world !== 1'b0) begin
      miscompares++; $display("FAIL reset_rst_world: got %b expected 0", o_rst_world);
    end
  endtask

  task automatic test_start();
    do_flap();
    vectors += 4;
    if (o_state !== 2'd1) begin
      miscompares++; $display("FAIL start_state: got %0d expected 1", o_state);
    end
    if (o_playing !== 1'b1) begin
      miscompares++; $display("FAIL start_playing: got %b expected 1", o_playing);
    end
    if (o_rst_world !== 1'b1) begin
      miscompares++; $display("FAIL start_rst_world: got %b expected 1", o_rst_world);
    end
    if (o_score !== 8'd0) begin
      miscompares++; $display("FAIL start_score: got %0d expected 0", o_score);
    end
    @(negedge i_clk);
    vectors++;
    if (o_rst_world !== 1'b0) begin
      miscompares++; $display("FAIL start_rst_world_width: got %b expected 0", o_rst_world);
    end
  endtask

  // Pipe left edge at 140 touches bird right edge 140; y ranges overlap.
  task automatic test_touch();
    logic n3, early;
    set_top(12'd140, 12'd200, 12'd0, 12'd210);
    for (int i = 0; i < 5; i++) begin
      run_frame(n3, early);
      vectors++;
      if ((n3 | early) !== 1'b0) begin
        miscompares++; $display("FAIL touch_hit[%0d]: got %b expected 0", i, n3 | early);
      end
    end
    vectors++;
    if (o_state !== 2'd1) begin
      miscompares++; $display("FAIL touch_state: got %0d expected 1", o_state);
    end
  endtask

  // Overlap frames separated by clear frames (touching, or an inverted empty rectangle).
  task automatic test_hit_filter();
    logic n3, early;
    for (int i = 0; i < 4; i++) begin
      set_top(12'd139, 12'd200, 12'd0, 12'd210);
      run_frame(n3, early);
      vectors++;
      if ((n3 | early) !== 1'b0) begin
        miscompares++; $display("FAIL filter_hit_a[%0d]: got %b expected 0", i, n3 | early);
      end
      if (i % 2 == 0) set_top(12'd140, 12'd200, 12'd0, 12'd210);
      else            set_top(12'd130, 12'd110, 12'd0, 12'd210);
      run_frame(n3, early);
      vectors++;
      if ((n3 | early) !== 1'b0) begin
        miscompares++; $display("FAIL filter_hit_b[%0d]: got %b expected 0", i, n3 | early);
      end
    end
    set_top(12'd140, 12'd200, 12'd0, 12'd210);
    run_frame(n3, early);
    vectors++;
    if (o_state !== 2'd1) begin
      miscompares++; $display("FAIL filter_state: got %0d expected 1", o_state);
    end
  endtask

  // Pipe above the bird (y 0..150) so x overlap is harmless; x2 walks 101 -> 97.
  task automatic test_score();
    logic n3, early;
    logic [7:0] exp_score [5] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
    for (int i = 0; i < 5; i++) begin
      set_top(12'd41 - 12'(i), 12'd101 - 12'(i), 12'd0, 12'd150);
      run_frame(n3, early);
      vectors++;
      if (o_score !== exp_score[i]) begin
        miscompares++; $display("FAIL score_step[%0d]: got %0d expected %0d", i, o_score, exp_score[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic n3, early;
    for (int i = 0; i < 98; i++) begin
      set_top(12'd40, 12'd100, 12'd0, 12'd150);
      run_frame(n3, early);
      set_top(12'd39, 12'd99, 12'd0, 12'd150);
      run_frame(n3, early);
    end
    vectors++;
    if (o_score !== 8'd99) begin
      miscompares++; $display("FAIL sat_reach: got %0d expected 99", o_score);
    end
    set_top(12'd40, 12'd100, 12'd0, 12'd150);
    run_frame(n3, early);
    set_top(12'd39, 12'd99, 12'd0, 12'd150);
    run_frame(n3, early);
    vectors++;
    if (o_score !== 8'd99) begin
      miscompares++; $display("FAIL sat_hold: got %0d expected 99", o_score);
    end
  endtask

  task automatic test_hit_over();
    logic n3, early;
    set_top(12'd139, 12'd200, 12'd0, 12'd210);
    run_frame(n3, early);
    vectors += 2;
    if (n3 !== 1'b0) begin
      miscompares++; $display("FAIL hit_first_frame: got %b expected 0", n3);
    end
    if (o_state !== 2'd1) begin
      miscompares++; $display("FAIL hit_first_state: got %0d expected 1", o_state);
    end
    run_frame(n3, early);
    vectors += 4;
    if (early !== 1'b0) begin
      miscompares++; $display("FAIL hit_early: got %b expected 0", early);
    end
    if (n3 !== 1'b1) begin
      miscompares++; $display("FAIL hit_pulse: got %b expected 1", n3);
    end
    if (o_state !== 2'd2) begin
      miscompares++; $display("FAIL hit_state: got %0d expected 2", o_state);
    end
    if (o_playing !== 1'b0) begin
      miscompares++; $display("FAIL hit_playing: got %b expected 0", o_playing);
    end
    @(negedge i_clk);
    vectors++;
    if (o_hit !== 1'b0) begin
      miscompares++; $display("FAIL hit_pulse_width: got %b expected 0", o_hit);
    end
    do_flap();
    vectors += 2;
    if (o_state !== 2'd2) begin
      miscompares++; $display("FAIL hit_flap_state: got %0d expected 2", o_state);
    end
    if (o_rst_world !== 1'b0) begin
      miscompares++; $display("FAIL hit_flap_rst_world: got %b expected 0", o_rst_world);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge i_clk) i_frame = 1'b1;
      @(negedge i_clk) i_frame = 1'b0;
      vectors++;
      if (o_state !== ((k == 3) ? 2'd3 : 2'd2)) begin
        miscompares++; $display("FAIL over_count[%0d]: got %0d expected %0d", k, o_state,
                                (k == 3) ? 3 : 2);
      end
    end
    vectors++;
    if (o_score !== 8'd99) begin
      miscompares++; $display("FAIL over_score_hold: got %0d expected 99", o_score);
    end
    do_flap();
    vectors += 3;
    if (o_state !== 2'd1) begin
      miscompares++; $display("FAIL restart_state: got %0d expected 1", o_state);
    end
    if (o_score !== 8'd0) begin
      miscompares++; $display("FAIL restart_score: got %0d expected 0", o_score);
    end
    if (o_rst_world !== 1'b1) begin
      miscompares++; $display("FAIL restart_rst_world: got %b expected 1", o_rst_world);
    end
  endtask

  task automatic test_reset_mid();
    logic n3, early;
    logic seen_hit;
    set_top(12'd139, 12'd200, 12'd0, 12'd210);
    run_frame(n3, early);
    vectors++;
    if ((n3 | early) !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_first: got %b expected 0", n3 | early);
    end
    @(negedge i_clk) i_frame = 1'b1;
    @(negedge i_clk) begin
      i_frame = 1'b0;
      i_rst   = 1'b1;
    end
    @(negedge i_clk) i_rst = 1'b0;
    seen_hit = o_hit;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      seen_hit = seen_hit | o_hit;
    end
    vectors += 5;
    if (seen_hit !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_hit: got %b expected 0", seen_hit);
    end
    if (o_state !== 2'd0) begin
      miscompares++; $display("FAIL rstmid_state: got %0d expected 0", o_state);
    end
    if (o_playing !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_playing: got %b expected 0", o_playing);
    end
    if (o_score !== 8'd0) begin
      miscompares++; $display("FAIL rstmid_score: got %0d expected 0", o_score);
    end
    if (o_rst_world !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_rst_world: got %b expected 0", o_rst_world);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1;
    i_frame = 1'b0;
    i_flap = 1'b0;
    bird_x1 = 12'd100; bird_x2 = 12'd140; bird_y1 = 12'd200; bird_y2 = 12'd230;
    set_top(12'd140, 12'd200, 12'd0, 12'd210);
    bot_x1 = 12'd140; bot_x2 = 12'd200; bot_y1 = 12'd300; bot_y2 = 12'd479;
    gnd_x1 = 12'd0;   gnd_x2 = 12'd639; gnd_y1 = 12'd440; gnd_y2 = 12'd479;
    test_reset();
    test_start();
    test_touch();
    test_hit_filter();
    test_score();
    test_saturation();
    test_hit_over();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
